// File: rtl/z80_mem_ctrl_if.sv
// z80_mem_ctrl_if
// Bundle of Z80 bus strobes and memory-side outputs shared between the Z80
// (master) and the memory-access controller (slave).
//
// Signals:
//   MREQ, IORQ, RD, WR, M1  Z80 strobes, active low, asynchronous to CLK_24MHz
//   A[15:0], D_IN[7:0]      Z80 address and data bus (input side)
//   D_OUT[7:0], D_OE        IO readback data and its drive enable
//   WAIT_N                  Z80 /WAIT, active low
//   M_A[4:0]                {M_A18..M_A14} page address
//   ROM_CE, RAM2_CE,
//   RAM0_CE, RAM1_CE        chip enables, active low
interface z80_mem_ctrl_if;
    logic        MREQ;
    logic        IORQ;
    logic        RD;
    logic        WR;
    logic        M1;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        WAIT_N;
    logic [4:0]  M_A;
    logic        ROM_CE;
    logic        RAM2_CE;
    logic        RAM0_CE;
    logic        RAM1_CE;

    modport master (
        output MREQ, IORQ, RD, WR, M1, A, D_IN,
        input  D_OUT, D_OE, WAIT_N, M_A, ROM_CE, RAM2_CE, RAM0_CE, RAM1_CE
    );

    modport slave (
        input  MREQ, IORQ, RD, WR, M1, A, D_IN,
        output D_OUT, D_OE, WAIT_N, M_A, ROM_CE, RAM2_CE, RAM0_CE, RAM1_CE
    );
endinterface

// File: rtl/z80_mem_ctrl.sv
// z80_mem_ctrl
// Memory-access controller for the Z80 board. Holds four 16 KB page-mapper
// registers and a wait-state register in IO space, drives the external page
// address and chip selects, and stretches slow-memory accesses with /WAIT.
//
// Ports:
//   CLK_24MHz  system clock
//   RST        synchronous, active-high reset
//   bus        z80_mem_ctrl_if.slave: Z80 strobes/address/data in,
//              readback data, WAIT_N, M_A and chip enables out
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for the Z80 strobes (clamped to >= 2)
//   WAIT_RST     reset value of the wait-count register
//   PORT_BASE    IO address of page0; page1..3 at +1..+3, wait register at +4
module z80_mem_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  WAIT_RST    = 8'd6,
    parameter logic [7:0]  PORT_BASE   = 8'h10
) (
    input logic           CLK_24MHz,
    input logic           RST,
    z80_mem_ctrl_if.slave bus
);

    localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Strobe synchronisers. Bit order: {M1, WR, RD, IORQ, MREQ}.
    // ------------------------------------------------------------------
    logic [4:0] strb_raw;
    logic [4:0] sync_q [Stages];
    logic       mreq_s, iorq_s, rd_s, wr_s, m1_s;

    assign strb_raw = {bus.M1, bus.WR, bus.RD, bus.IORQ, bus.MREQ};

    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= strb_raw;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign mreq_s = sync_q[Stages-1][0];
    assign iorq_s = sync_q[Stages-1][1];
    assign rd_s   = sync_q[Stages-1][2];
    assign wr_s   = sync_q[Stages-1][3];
    assign m1_s   = sync_q[Stages-1][4];

    // ------------------------------------------------------------------
    // IO port decode and register file
    // ------------------------------------------------------------------
    logic [7:0] port_off;
    logic       port_hit;
    logic [2:0] port_idx;
    logic       iowr_s;
    logic       iowr_q;
    logic       io_wr_pulse;
    logic [7:0] page_q [4];
    logic [7:0] wait_reg_q;
    logic [7:0] rd_data;

    // Modular subtraction keeps the decode correct for any PORT_BASE.
    assign port_off = bus.A[7:0] - PORT_BASE;
    assign port_hit = (port_off < 8'd5);
    assign port_idx = port_off[2:0];

    // A write is taken once, on the cycle the combined IORQ|WR strobe falls.
    // M1 low marks an interrupt acknowledge, which must not write anything.
    assign iowr_s      = iorq_s | wr_s;
    assign io_wr_pulse = iowr_q & ~iowr_s & m1_s;

    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            iowr_q     <= 1'b1;
            wait_reg_q <= WAIT_RST;
            for (int i = 0; i < 4; i++) begin
                page_q[i] <= 8'h00;
            end
        end else begin
            iowr_q <= iowr_s;
            if (io_wr_pulse && port_hit) begin
                if (port_idx == 3'd4) begin
                    wait_reg_q <= bus.D_IN;
                end else begin
                    page_q[port_idx[1:0]] <= bus.D_IN;
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (port_idx)
            3'd0:    rd_data = page_q[0];
            3'd1:    rd_data = page_q[1];
            3'd2:    rd_data = page_q[2];
            3'd3:    rd_data = page_q[3];
            3'd4:    rd_data = wait_reg_q;
            default: rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // IO readback
    // ------------------------------------------------------------------
    logic       rd_active;
    logic       d_oe_q;
    logic [7:0] d_out_q;

    assign rd_active = ~iorq_s & ~rd_s & m1_s & port_hit;

    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            d_oe_q  <= 1'b0;
            d_out_q <= 8'h00;
        end else begin
            d_oe_q  <= rd_active;
            d_out_q <= rd_active ? rd_data : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Page mapping and chip selects
    // ------------------------------------------------------------------
    logic [7:0] sel;
    logic [3:0] ce_d;   // {ROM, RAM2, RAM0, RAM1}, active low
    logic [3:0] ce_q;
    logic [4:0] m_a_q;
    logic       unused_sel;
    logic       unused_a;

    assign sel = page_q[bus.A[15:14]];

    // sel[7] is stored and read back only; A[13:8] never affects decode.
    assign unused_sel = sel[7];
    assign unused_a   = ^bus.A[13:8];

    always_comb begin
        ce_d = 4'b1111;
        if (!mreq_s) begin
            if (sel[6]) begin
                ce_d = {1'b1, 1'b1, sel[1], ~sel[1]};
            end else begin
                ce_d = {sel[5], ~sel[5], 1'b1, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            ce_q  <= 4'b1111;
            m_a_q <= 5'd0;
        end else begin
            ce_q  <= ce_d;
            m_a_q <= sel[4:0];
        end
    end

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wait_n_q, wait_n_d;
    logic       mem_access;

    // MREQ low alone is a refresh cycle and must not be stretched.
    assign mem_access = ~mreq_s & (~rd_s | ~wr_s);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_n_d = 1'b1;
        case (state_q)
            StIdle: begin
                if (mem_access) begin
                    if (!sel[6] && (wait_reg_q != 8'd0)) begin
                        state_d  = StCount;
                        cnt_d    = wait_reg_q;
                        wait_n_d = 1'b0;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StCount: begin
                if (mreq_s) begin
                    // Access abandoned mid-wait: release /WAIT at once.
                    state_d = StIdle;
                end else if (cnt_q <= 8'd1) begin
                    state_d = StHold;
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    wait_n_d = 1'b0;
                end
            end
            StHold: begin
                // Stay here until MREQ rises so one access gets one burst.
                if (mreq_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            wait_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_n_q <= wait_n_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.D_OUT   = d_out_q;
    assign bus.D_OE    = d_oe_q;
    assign bus.WAIT_N  = wait_n_q;
    assign bus.M_A     = m_a_q;
    assign bus.ROM_CE  = ce_q[3];
    assign bus.RAM2_CE = ce_q[2];
    assign bus.RAM0_CE = ce_q[1];
    assign bus.RAM1_CE = ce_q[0];

endmodule

// File: tb/tb_z80_mem_ctrl.sv
`timescale 1ns/1ps
module tb_z80_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #21 clk = ~clk;

    z80_mem_ctrl_if bus();

    z80_mem_ctrl #(
        .SYNC_STAGES(2),
        .WAIT_RST(8'd6),
        .PORT_BASE(8'h10)
    ) dut (
        .CLK_24MHz(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the programmable state.
    logic [7:0] m_page [4];
    logic [7:0] m_wait;

    typedef struct {
        logic [4:0] m_a;
        logic [3:0] ce;     // {ROM, RAM2, RAM0, RAM1}
        int         waits;
    } mem_exp_t;

    typedef struct {
        logic       oe;
        logic [7:0] data;
    } io_exp_t;

    mem_exp_t mem_q[$];
    io_exp_t  io_q[$];

    localparam int KindRead    = 0;
    localparam int KindWrite   = 1;
    localparam int KindRefresh = 2;

    function automatic mem_exp_t predict(input logic [15:0] addr, input int kind);
        mem_exp_t   e;
        logic [7:0] s;
        s     = m_page[addr[15:14]];
        e.m_a = s[4:0];
        if (s[6]) e.ce = s[1] ? 4'b1110 : 4'b1101;
        else      e.ce = s[5] ? 4'b1011 : 4'b0111;
        if (kind == KindRefresh || s[6] || m_wait == 8'd0) e.waits = 0;
        else                                                e.waits = int'(m_wait);
        return e;
    endfunction

    task automatic bus_idle();
        bus.MREQ = 1'b1;
        bus.IORQ = 1'b1;
        bus.RD   = 1'b1;
        bus.WR   = 1'b1;
        bus.M1   = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_page[i] = 8'h00;
        m_wait = 8'd6;
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] data);
        logic [7:0] off;
        off = port - 8'h10;
        if (off < 8'd4)       m_page[off[1:0]] = data;
        else if (off == 8'd4) m_wait = data;
        @(negedge clk);
        bus.A    = {8'h00, port};
        bus.D_IN = data;
        bus.IORQ = 1'b0;
        bus.WR   = 1'b0;
        repeat (4) @(negedge clk);
        bus_idle();
        repeat (4) @(negedge clk);
    endtask

    task automatic io_in(input logic [7:0] port, input string tag);
        io_exp_t    e;
        logic [7:0] off;
        logic       oe_s;
        logic [7:0] d_s;
        off    = port - 8'h10;
        e.oe   = (off < 8'd5);
        e.data = (off < 8'd4) ? m_page[off[1:0]] : ((off == 8'd4) ? m_wait : 8'h00);
        io_q.push_back(e);
        @(negedge clk);
        bus.A    = {8'h00, port};
        bus.IORQ = 1'b0;
        bus.RD   = 1'b0;
        repeat (5) @(negedge clk);
        oe_s = bus.D_OE;
        d_s  = bus.D_OUT;
        bus_idle();
        e = io_q.pop_front();
        checks++;
        if (oe_s !== e.oe) begin
            errors++;
            $display("FAIL %s d_oe got %b want %b", tag, oe_s, e.oe);
        end
        if (e.oe) begin
            checks++;
            if (d_s !== e.data) begin
                errors++;
                $display("FAIL %s d_out got %h want %h", tag, d_s, e.data);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.D_OE !== 1'b0) begin
            errors++;
            $display("FAIL %s d_oe_release got %b want 0", tag, bus.D_OE);
        end
    endtask

    // One memory cycle; counts WAIT_N-low cycles over a fixed window.
    task automatic mem_access(input logic [15:0] addr, input int kind, input string tag);
        mem_exp_t   e;
        int         lows;
        logic [4:0] ma_s;
        logic [3:0] ce_s;
        mem_q.push_back(predict(addr, kind));
        @(negedge clk);
        bus.A    = addr;
        bus.MREQ = 1'b0;
        @(negedge clk);
        if (kind == KindRead) bus.RD = 1'b0;
        if (kind == KindWrite) begin
            bus.D_IN = 8'hA5;
            bus.WR   = 1'b0;
        end
        lows = 0;
        ma_s = '0;
        ce_s = '1;
        for (int i = 0; i < 262; i++) begin
            @(negedge clk);
            if (bus.WAIT_N === 1'b0) lows++;
            if (i == 5) begin
                ma_s = bus.M_A;
                ce_s = {bus.ROM_CE, bus.RAM2_CE, bus.RAM0_CE, bus.RAM1_CE};
            end
        end
        bus_idle();
        e = mem_q.pop_front();
        checks++;
        if (ma_s !== e.m_a) begin
            errors++;
            $display("FAIL %s m_a got %h want %h", tag, ma_s, e.m_a);
        end
        checks++;
        if (ce_s !== e.ce) begin
            errors++;
            $display("FAIL %s ce got %b want %b", tag, ce_s, e.ce);
        end
        checks++;
        if (lows != e.waits) begin
            errors++;
            $display("FAIL %s wait_cycles got %0d want %0d", tag, lows, e.waits);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.ROM_CE, bus.RAM2_CE, bus.RAM0_CE, bus.RAM1_CE} !== 4'b1111) begin
            errors++;
            $display("FAIL %s ce_idle got %b want 1111", tag,
                     {bus.ROM_CE, bus.RAM2_CE, bus.RAM0_CE, bus.RAM1_CE});
        end
    endtask

    task automatic wait_for_wait_low(input string tag);
        int n;
        n = 0;
        while (bus.WAIT_N !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.WAIT_N !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_start got %b want 0", tag, bus.WAIT_N);
        end
    endtask

    task automatic test_reset();
        bus_idle();
        bus.A    = 16'h0000;
        bus.D_IN = 8'h00;
        rst      = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.WAIT_N, bus.D_OE, bus.D_OUT} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset wait_oe_dout got %b_%b_%h want 1_0_00",
                     bus.WAIT_N, bus.D_OE, bus.D_OUT);
        end
        checks++;
        if ({bus.ROM_CE, bus.RAM2_CE, bus.RAM0_CE, bus.RAM1_CE, bus.M_A} !== 9'b1111_00000)
        begin
            errors++;
            $display("FAIL reset ce_ma got %b want 111100000",
                     {bus.ROM_CE, bus.RAM2_CE, bus.RAM0_CE, bus.RAM1_CE, bus.M_A});
        end
        io_in(8'h14, "reset_wait_reg");
        io_in(8'h13, "reset_page3");
    endtask

    task automatic test_slow_rom();
        mem_access(16'h0000, KindRead, "rom_read");
    endtask

    task automatic test_fast_ram();
        io_out(8'h12, 8'h43);
        mem_access(16'h8000, KindRead, "fast_43");
        io_out(8'h12, 8'h42);
        mem_access(16'h8000, KindRead, "fast_42");
        io_out(8'h12, 8'h41);
        mem_access(16'h8123, KindRead, "fast_41");
    endtask

    task automatic test_ram2_write();
        io_out(8'h11, 8'h27);
        mem_access(16'h4123, KindWrite, "ram2_write");
        io_in(8'h11, "readback_page1");
        io_in(8'h12, "readback_page2");
        io_in(8'h15, "readback_unmapped");
        io_out(8'h13, 8'hC0);
        io_in(8'h13, "readback_page3_bit7");
        mem_access(16'hC000, KindRead, "fast_bit7");
    endtask

    task automatic test_refresh();
        mem_access(16'h0000, KindRefresh, "refresh");
    endtask

    task automatic test_int_ack();
        @(negedge clk);
        bus.A    = 16'h0010;
        bus.D_IN = 8'h99;
        bus.M1   = 1'b0;
        bus.IORQ = 1'b0;
        bus.WR   = 1'b0;
        bus.RD   = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.D_OE !== 1'b0) begin
            errors++;
            $display("FAIL int_ack d_oe got %b want 0", bus.D_OE);
        end
        bus_idle();
        repeat (4) @(negedge clk);
        io_in(8'h10, "int_ack_page0");
    endtask

    task automatic test_wait_reg();
        int n;
        io_out(8'h14, 8'h00);
        mem_access(16'h0000, KindRead, "wait_zero");
        io_out(8'h14, 8'hFF);
        mem_access(16'h0000, KindRead, "wait_255");
        // Abandon a long wait after 10 cycles.
        @(negedge clk);
        bus.A    = 16'h0000;
        bus.MREQ = 1'b0;
        @(negedge clk);
        bus.RD = 1'b0;
        wait_for_wait_low("abort");
        repeat (10) @(negedge clk);
        checks++;
        if (bus.WAIT_N !== 1'b0) begin
            errors++;
            $display("FAIL abort still_waiting got %b want 0", bus.WAIT_N);
        end
        bus_idle();
        n = 0;
        while (bus.WAIT_N !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        // Two synchroniser stages plus the registered WAIT_N.
        @(negedge clk);
        checks++;
        if (n != 3 || bus.WAIT_N !== 1'b1) begin
            errors++;
            $display("FAIL abort release_cycles got %0d want 3", n);
        end
        repeat (4) @(negedge clk);
        io_out(8'h14, 8'd3);
        mem_access(16'h0000, KindRead, "after_abort");
    endtask

    task automatic test_reset_mid();
        io_out(8'h14, 8'd20);
        io_out(8'h11, 8'h55);
        @(negedge clk);
        bus.A    = 16'h0000;
        bus.MREQ = 1'b0;
        @(negedge clk);
        bus.RD = 1'b0;
        wait_for_wait_low("rst_mid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus_idle();
        @(negedge clk);
        checks++;
        if (bus.WAIT_N !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid wait_n got %b want 1", bus.WAIT_N);
        end
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        io_in(8'h14, "rst_mid_wait_reg");
        io_in(8'h11, "rst_mid_page1");
        mem_access(16'h0000, KindRead, "rst_mid_access");
    endtask

    initial begin
        test_reset();
        test_slow_rom();
        test_fast_ram();
        test_ram2_write();
        test_refresh();
        test_int_ack();
        test_wait_reg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
